fetch_mem_responder: RTL and testbench
======================================

Name: fetch_mem_responder

Overview:
- Responder side of the fetch-stage instruction request: takes the PC driven by the fetch stage and returns the instruction word at that address.
- Holds a single-entry instruction buffer. On a buffer miss it issues a handshaked request to the backing instruction memory and stalls the fetch stage; the stall drives the fetch stage's PC enable low.
- Sits between the fetch stage and the instruction memory/bus.

Parameters:
- WIDTH, 8: address width; matches the fetch-stage PC width.
- INSTR_WIDTH, 64: instruction word width; 8 bytes, matching the PC+8 step.
- TIMEOUT, 15: maximum cycles waiting for mem_ack before the request is abandoned.
- CNT_WIDTH, 4: timeout counter width; must hold TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- fetch_req  input  1  fetch stage requests the instruction at fetch_addr.
- fetch_addr  input  WIDTH  PC from the fetch stage (PCF).
- flush  input  1  branch taken or PC redirect; discard any in-flight miss.
- instr  output  INSTR_WIDTH  instruction word.
- instr_valid  output  1  instr is valid for fetch_addr this cycle.
- stall  output  1  hold PC; the fetch stage uses enablePCFlipFlop = ~stall.
- fetch_err  output  1  one-cycle pulse on memory timeout.
- mem_req  output  1  request to instruction memory.
- mem_addr  output  WIDTH  word-aligned request address.
- mem_rdata  input  INSTR_WIDTH  memory read data.
- mem_ack  input  1  memory data valid; completes the request.

Behaviour:
- Reset (reset=0, async): state=IDLE; buf_valid=0, buf_addr=0, buf_instr=0; mem_req=0, mem_addr=0; counter=0; discard=0; fetch_err=0. Outputs instr=0, instr_valid=0, stall=0. An in-flight request is abandoned and mem_req drops immediately.
- Address compare ignores fetch_addr[2:0]; mem_addr always has [2:0]=0.
- Hit:
  - Condition: fetch_req & buf_valid & addr match & state==IDLE.
  - Response is combinational, same cycle: instr=buf_instr, instr_valid=1, stall=0.
- Miss in IDLE:
  - Same cycle: stall=1, instr_valid=0.
  - Next edge: state->REQ, mem_addr captured, mem_req=1 (registered), counter=0.
- REQ:
  - mem_req and mem_addr held stable until mem_ack.
  - Each cycle without ack, counter increments.
  - stall=1 throughout, unless discard or flush is set (see flush rules).
  - On mem_ack: if discard=0, then buf_instr<=mem_rdata, buf_addr<=mem_addr, buf_valid<=1. Then mem_req<=0, discard<=0, state->IDLE.
  - The following cycle the unchanged PC hits. Miss latency = ack latency + 2 cycles from miss detection to instr_valid.
- mem_ack outside REQ: ignored.
- Timeout:
  - Trigger: counter==TIMEOUT without ack.
  - Effect: fetch_err=1 for one cycle, mem_req<=0, state->IDLE, buffer unchanged, discard cleared.
  - The fetch stage retries by re-requesting, which causes a new miss.
- Flush:
  - In IDLE: no effect on the buffer; instr_valid is forced 0 that cycle.
  - In REQ: discard<=1. The handshake still completes (mem_req held until ack or timeout) but data is dropped.
  - stall is deasserted from the cycle after flush, so the fetch stage can load the redirect target. A new fetch_req on a different address is not serviced until state returns to IDLE; stall=1 in that window.
- flush coincident with mem_ack in REQ: data dropped, state->IDLE.
- fetch_req=0: instr_valid=0, stall=0; an in-flight miss still completes and fills the buffer.
- fetch_addr or fetch_req changing while stalled without flush is a protocol violation. Fill uses the captured address.

Decomposition:
- Package fetch_resp_pkg holds:
  - Enum state_t {IDLE, REQ}.
  - Constant INSTR_BYTES=8 and ALIGN_BITS=3.
- Sub-module: none required. Optional fetch_line_buffer holds buf_valid/buf_addr/buf_instr with fill and compare.

Test Plan:
1. Reset, then fetch_req at addr 0x00; memory acks 2 cycles after mem_req with 0x1122334455667788 -> stall=1 for 4 cycles, mem_addr=0x00, then instr=0x1122334455667788, instr_valid=1, stall=0.
2. Repeat fetch of 0x00, then 0x04 -> both hit, no mem_req (low bits ignored); 0x08 -> miss, mem_addr=0x08.
3. Miss on 0x10, flush asserted the cycle after mem_req, ack with 0xDEAD -> buffer not written, stall=0 after flush; a later fetch of 0x10 misses again.
4. Miss on 0x18 with no mem_ack -> fetch_err pulses exactly once, TIMEOUT+1 cycles after mem_req rises; mem_req=0; state IDLE; buf_addr unchanged.
5. reset driven low mid-REQ, asynchronous to clk -> mem_req, stall and instr_valid go 0 immediately; buf_valid=0 after release.
6. flush and mem_ack in the same cycle -> data dropped, IDLE next cycle, no fetch_err.

Source files
------------

// File: rtl/fetch_resp_pkg.sv
// fetch_resp_pkg: shared state encoding and alignment constants for the fetch responder.
package fetch_resp_pkg;
   typedef enum logic {IDLE, REQ} state_t;
   localparam int INSTR_BYTES = 8;
   localparam int ALIGN_BITS = 3;
endpackage

// File: rtl/fetch_line_buffer.sv
// fetch_line_buffer: single-entry instruction buffer with fill and word-address compare.
module fetch_line_buffer
   import fetch_resp_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int INSTR_WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   fill,
   input  logic [WIDTH-1:0]       fill_addr,
   input  logic [INSTR_WIDTH-1:0] fill_data,
   input  logic [WIDTH-1:0]       lookup_addr,
   output logic                   hit,
   output logic [INSTR_WIDTH-1:0] data
);
   logic             valid;
   logic [WIDTH-1:0] tag;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         valid <= 1'b0;
         tag   <= '0;
         data  <= '0;
      end else if (fill) begin
         valid <= 1'b1;
         tag   <= fill_addr;
         data  <= fill_data;
      end
   // byte offset within the word is shifted out before comparing
   assign hit = valid && ((tag ^ lookup_addr) >> ALIGN_BITS) == '0;
endmodule

// File: rtl/fetch_mem_responder.sv
// fetch_mem_responder: serves fetch-stage PCs from a one-entry buffer, stalling the
// fetch stage while a miss is fetched from instruction memory with a bounded wait.
module fetch_mem_responder
   import fetch_resp_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int INSTR_WIDTH = 64,
   parameter int TIMEOUT = 15,
   parameter int CNT_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   fetch_req,
   input  logic [WIDTH-1:0]       fetch_addr,
   input  logic                   flush,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic                   instr_valid,
   output logic                   stall,
   output logic                   fetch_err,
   output logic                   mem_req,
   output logic [WIDTH-1:0]       mem_addr,
   input  logic [INSTR_WIDTH-1:0] mem_rdata,
   input  logic                   mem_ack
);
   state_t                 state, state_nx;
   logic [CNT_WIDTH-1:0]   count;
   logic                   discard, buf_hit, hit, miss, done, expire, fill;
   logic [INSTR_WIDTH-1:0] buf_instr;

   fetch_line_buffer #(.WIDTH(WIDTH), .INSTR_WIDTH(INSTR_WIDTH)) line_buffer (
      .clk(clk),
      .reset(reset),
      .fill(fill),
      .fill_addr(mem_addr),
      .fill_data(mem_rdata),
      .lookup_addr(fetch_addr),
      .hit(buf_hit),
      .data(buf_instr)
   );

   assign hit    = state == IDLE && fetch_req && buf_hit;
   assign miss   = state == IDLE && fetch_req && !flush && !buf_hit;
   assign done   = state == REQ && mem_ack;
   assign expire = state == REQ && !mem_ack && count == CNT_WIDTH'(TIMEOUT);
   assign fill   = done && !discard && !flush;

   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_nx;

   // outputs are gated by reset so they fall the moment reset asserts
   always_comb begin
      state_nx = state;
      if (miss) state_nx = REQ;
      else if (done || expire) state_nx = IDLE;
      instr_valid = reset && hit && !flush;
      instr = instr_valid ? buf_instr : '0;
      stall = reset && (state == REQ ? fetch_req && !flush : miss);
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         count     <= '0;
         discard   <= 1'b0;
         fetch_err <= 1'b0;
      end else begin
         fetch_err <= expire;
         if (miss) begin
            mem_req  <= 1'b1;
            mem_addr <= {fetch_addr[WIDTH-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
            count    <= '0;
            discard  <= 1'b0;
         end else if (done || expire) begin
            mem_req <= 1'b0;
            discard <= 1'b0;
         end else if (state == REQ) begin
            count <= count + 1'b1;
            if (flush) discard <= 1'b1;
         end
      end
endmodule

// File: tb/tb_fetch_mem_responder.sv
// tb_fetch_mem_responder: scenario tasks checked against a one-entry buffer model.
module tb_fetch_mem_responder;
   logic        clk = 0, reset = 0, fetch_req = 0, flush = 0, mem_ack = 0;
   logic [7:0]  fetch_addr = 0;
   logic [63:0] mem_rdata = 0;
   logic [63:0] instr;
   logic        instr_valid, stall, fetch_err, mem_req;
   logic [7:0]  mem_addr;
   int          tests = 0, fails = 0;
   logic        m_valid = 0;
   logic [7:0]  m_addr = 0;
   logic [63:0] m_instr = 0;

   always #5 clk = ~clk;

   fetch_mem_responder dut (
      .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr), .flush(flush),
      .instr(instr), .instr_valid(instr_valid), .stall(stall), .fetch_err(fetch_err),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   function automatic logic m_hit(input logic [7:0] a);
      return m_valid && a[7:3] == m_addr[7:3];
   endfunction

   task automatic do_miss(input logic [7:0] a, input logic [63:0] d, input int lat);
      int   st;
      logic bad;
      st = 0;
      bad = 0;
      @(negedge clk); fetch_req = 1; fetch_addr = a; #1;
      tests++; if (stall !== 1'b1 || instr_valid !== 1'b0) begin fails++; $display("FAIL miss_detect a=%h stall=%b valid=%b, want 1/0", a, stall, instr_valid); end
      st += int'(stall);
      for (int i = 0; i <= lat; i++) begin
         @(negedge clk); mem_ack = (i == lat); mem_rdata = d; #1;
         if (mem_req !== 1'b1 || mem_addr !== (a & 8'hf8)) bad = 1;
         st += int'(stall);
      end
      @(negedge clk); mem_ack = 0; #1;
      tests++; if (bad) begin fails++; $display("FAIL miss_req a=%h mem_addr=%h, want req held at %h", a, mem_addr, a & 8'hf8); end
      tests++; if (st != lat + 2) begin fails++; $display("FAIL miss_stall_cycles got %0d want %0d", st, lat + 2); end
      m_valid = 1; m_addr = a; m_instr = d;
      tests++; if (instr_valid !== 1'b1 || instr !== d || stall !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL miss_fill valid=%b instr=%h stall=%b req=%b, want 1/%h/0/0", instr_valid, instr, stall, mem_req, d); end
   endtask

   task automatic test_reset;
      fetch_req = 1; fetch_addr = 8'($urandom); #2;
      tests++; if (stall !== 1'b0 || instr_valid !== 1'b0 || instr !== 64'd0) begin fails++; $display("FAIL reset_outputs stall=%b valid=%b instr=%h, want 0", stall, instr_valid, instr); end
      tests++; if (mem_req !== 1'b0 || mem_addr !== 8'd0 || fetch_err !== 1'b0) begin fails++; $display("FAIL reset_mem req=%b addr=%h err=%b, want 0", mem_req, mem_addr, fetch_err); end
      @(negedge clk); fetch_req = 0; reset = 1;
      @(negedge clk); #1;
      tests++; if (stall !== 1'b0 || instr_valid !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL idle_after_reset stall=%b valid=%b req=%b, want 0", stall, instr_valid, mem_req); end
   endtask

   task automatic test_first_miss;
      do_miss(8'h00, 64'h1122334455667788, 2);
   endtask

   task automatic test_low_bits;
      logic [7:0] addrs [2] = '{8'h00, 8'h04};
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); fetch_req = 1; fetch_addr = addrs[i]; #1;
         tests++; if (instr_valid !== 1'b1 || instr !== m_instr || stall !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL low_bits_hit a=%h valid=%b instr=%h stall=%b, want 1/%h/0", addrs[i], instr_valid, instr, stall, m_instr); end
      end
      do_miss(8'h08, {$urandom, $urandom}, 1);
   endtask

   task automatic test_flush;
      @(negedge clk); fetch_req = 1; fetch_addr = 8'h10; #1;
      @(negedge clk); #1;
      tests++; if (mem_req !== 1'b1 || mem_addr !== 8'h10) begin fails++; $display("FAIL flush_req req=%b addr=%h, want 1/10", mem_req, mem_addr); end
      @(negedge clk); flush = 1; #1;
      @(negedge clk); flush = 0; fetch_req = 0; #1;
      tests++; if (stall !== 1'b0 || mem_req !== 1'b1) begin fails++; $display("FAIL flush_stall stall=%b req=%b, want 0/1", stall, mem_req); end
      @(negedge clk); mem_ack = 1; mem_rdata = 64'hDEAD; #1;
      @(negedge clk); mem_ack = 0; #1;
      tests++; if (mem_req !== 1'b0 || fetch_err !== 1'b0) begin fails++; $display("FAIL flush_done req=%b err=%b, want 0/0", mem_req, fetch_err); end
      do_miss(8'h10, {$urandom, $urandom}, 1);
   endtask

   task automatic test_timeout;
      int   first, pulses;
      logic req_at_err;
      first = 0; pulses = 0; req_at_err = 1'bx;
      @(negedge clk); fetch_req = 1; fetch_addr = 8'h18; #1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk); #1;
         if (fetch_err === 1'b1) begin
            pulses++;
            if (first == 0) begin first = c; req_at_err = mem_req; end
            fetch_req = 0;
         end
      end
      tests++; if (first != 17) begin fails++; $display("FAIL timeout_cycle got %0d want 17", first); end
      tests++; if (pulses != 1) begin fails++; $display("FAIL timeout_pulses got %0d want 1", pulses); end
      tests++; if (req_at_err !== 1'b0) begin fails++; $display("FAIL timeout_req got %b want 0", req_at_err); end
      @(negedge clk); fetch_req = 1; fetch_addr = m_addr; #1;
      tests++; if (instr_valid !== 1'b1 || instr !== m_instr || stall !== 1'b0) begin fails++; $display("FAIL timeout_buffer valid=%b instr=%h, want 1/%h", instr_valid, instr, m_instr); end
   endtask

   task automatic test_flush_ack;
      logic [7:0] a;
      logic       err_seen;
      a = m_addr ^ 8'h40;
      err_seen = 0;
      @(negedge clk); fetch_req = 1; fetch_addr = a; #1;
      @(negedge clk); #1;
      @(negedge clk); flush = 1; mem_ack = 1; mem_rdata = {$urandom, $urandom}; #1;
      tests++; if (stall !== 1'b0 || instr_valid !== 1'b0) begin fails++; $display("FAIL flush_ack_stall stall=%b valid=%b, want 0/0", stall, instr_valid); end
      @(negedge clk); flush = 0; mem_ack = 0; fetch_req = 0; #1;
      tests++; if (mem_req !== 1'b0 || fetch_err !== 1'b0) begin fails++; $display("FAIL flush_ack_idle req=%b err=%b, want 0/0", mem_req, fetch_err); end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); #1;
         if (fetch_err !== 1'b0) err_seen = 1;
      end
      tests++; if (err_seen) begin fails++; $display("FAIL flush_ack_err got pulse want none"); end
      do_miss(a, {$urandom, $urandom}, 0);
   endtask

   task automatic test_async_reset;
      logic [7:0] old;
      old = m_addr;
      @(negedge clk); fetch_req = 1; fetch_addr = old ^ 8'h80; #1;
      @(negedge clk); #1;
      @(negedge clk); #3; reset = 0; #1;
      tests++; if (mem_req !== 1'b0 || stall !== 1'b0 || instr_valid !== 1'b0) begin fails++; $display("FAIL async_reset req=%b stall=%b valid=%b, want 0", mem_req, stall, instr_valid); end
      @(negedge clk); fetch_req = 0; reset = 1;
      m_valid = 0;
      do_miss(old, {$urandom, $urandom}, 3);
   endtask

   task automatic test_random;
      logic [7:0] a;
      for (int n = 0; n < 30; n++) begin
         a = $urandom_range(0, 1) ? {m_addr[7:3], 3'($urandom)} : 8'($urandom);
         if ($urandom_range(0, 4) == 0) begin
            @(negedge clk); fetch_req = 0; fetch_addr = a; #1;
            tests++; if (stall !== 1'b0 || instr_valid !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL rand_idle stall=%b valid=%b req=%b, want 0", stall, instr_valid, mem_req); end
         end else if (m_hit(a)) begin
            @(negedge clk); fetch_req = 1; fetch_addr = a; #1;
            tests++; if (instr_valid !== 1'b1 || instr !== m_instr || stall !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL rand_hit a=%h valid=%b instr=%h, want 1/%h", a, instr_valid, instr, m_instr); end
         end else do_miss(a, {$urandom, $urandom}, $urandom_range(0, 5));
      end
   endtask

   initial begin
      test_reset;
      test_first_miss;
      test_low_bits;
      test_flush;
      test_timeout;
      test_flush_ack;
      test_async_reset;
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end
endmodule
